quickq_head: RTL and testbench

QUICKQ_HEAD -- requirements
Module: quickq_head

---
 rtl/quickq_pkg.sv | 37 +++
 rtl/quickq_sat_ctr.sv | 26 ++
 rtl/quickq_head.sv | 189 ++++++++++++++++++
 tb/tb_quickq_head.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quickq_pkg.sv
// Shared types and defaults for the quickq head controller and its node chain.
// Holds the head FSM states, default sizing and the command-pulse encoding for node 0.
package quickq_pkg;

    localparam int QQ_DATA_W = 16;
    localparam int QQ_DEPTH  = 64;
    localparam int QQ_RD_LAT = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        GAP   = 3'd2,
        READ  = 3'd3,
        WAIT  = 3'd4,
        CLEAR = 3'd5
    } head_state_t;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_READ  = 2'd2,
        CMD_RESET = 2'd3
    } node_cmd_t;

    // Decodes a command into the {write, read, reset} pulse lines; one-hot by construction.
    function automatic logic [2:0] cmd_to_pulses(input node_cmd_t cmd);
        logic [2:0] pulses;
        case (cmd)
            CMD_WRITE: pulses = 3'b100;
            CMD_READ:  pulses = 3'b010;
            CMD_RESET: pulses = 3'b001;
            default:   pulses = 3'b000;
        endcase
        return pulses;
    endfunction

endpackage

// File: rtl/quickq_sat_ctr.sv
// Saturating event counter used for the optional enqueue/dequeue statistics.
module quickq_sat_ctr #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_r;

    // Count events, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            count_r <= {W{1'b0}};
        end else if (inc_i && (count_r != {W{1'b1}})) begin
            count_r <= count_r + W'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count_o = count_r;

endmodule

// File: rtl/quickq_head.sv
// Head controller of the quickq node chain: arbitrates host requests into node commands.
// Optional statistics ports are built only when QUICKQ_HEAD_STATS_EN is defined.
module quickq_head
    import quickq_pkg::*;
#(
    parameter int DATA_W = QQ_DATA_W,
    parameter int DEPTH  = QQ_DEPTH,
    parameter int RD_LAT = QQ_RD_LAT
) (
    input  logic                       clk,
    input  logic                       reset_i,
    input  logic                       enq_valid_i,
    input  logic [DATA_W-1:0]          enq_data_i,
    output logic                       enq_ready_o,
    input  logic                       deq_req_i,
    output logic                       deq_ready_o,
    output logic                       deq_valid_o,
    output logic [DATA_W-1:0]          deq_data_o,
    input  logic                       clr_i,
    output logic                       node_write_o,
    output logic                       node_read_o,
    output logic                       node_reset_o,
    output logic [DATA_W-1:0]          node_data_o,
    input  logic [DATA_W-1:0]          node_data_i,
`ifdef QUICKQ_HEAD_STATS_EN
    output logic [31:0]                enq_cnt_o,
    output logic [31:0]                deq_cnt_o,
`endif
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(RD_LAT - 1);

    head_state_t       state_r;
    head_state_t       state_s;
    node_cmd_t         cmd_s;
    logic [2:0]        pulses_s;
    logic [CNT_W-1:0]  count_r;
    logic [WAIT_W-1:0] wait_r;
    logic [DATA_W-1:0] node_data_r;
    logic [DATA_W-1:0] deq_data_r;
    logic              deq_valid_r;
    logic              full_s;
    logic              empty_s;
    logic              enq_ready_s;
    logic              deq_ready_s;
    logic              enq_fire_s;
    logic              clr_fire_s;
    logic              deq_done_s;

    assign full_s     = (count_r == FULL_CNT);
    assign empty_s    = (count_r == {CNT_W{1'b0}});
    assign enq_fire_s = enq_valid_i & enq_ready_s;
    assign clr_fire_s = (state_r == IDLE) & clr_i & ~reset_i;
    // Last WAIT cycle: node_data_i is valid now and is captured at this edge.
    assign deq_done_s = (state_r == WAIT) & (wait_r == {WAIT_W{1'b0}}) & ~reset_i;

    // State register.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; only IDLE looks at host requests, with clear > dequeue > enqueue.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (clr_i) begin
                    state_s = CLEAR;
                end else if (deq_req_i && !empty_s) begin
                    state_s = READ;
                end else if (enq_valid_i && !full_s) begin
                    state_s = WRITE;
                end else begin
                    state_s = IDLE;
                end
            end
            WRITE:   state_s = GAP;
            GAP:     state_s = IDLE;
            READ:    state_s = WAIT;
            WAIT: begin
                if (wait_r == {WAIT_W{1'b0}}) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT;
                end
            end
            CLEAR:   state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Output decode: node command and host handshakes; reset_i overrides everything.
    always_comb begin
        cmd_s       = CMD_NONE;
        enq_ready_s = 1'b0;
        deq_ready_s = 1'b0;
        if (reset_i) begin
            cmd_s = CMD_RESET;
        end else begin
            case (state_r)
                IDLE: begin
                    enq_ready_s = ~full_s & ~clr_i & ~(deq_req_i & ~empty_s);
                    deq_ready_s = ~empty_s & ~clr_i;
                end
                WRITE:   cmd_s = CMD_WRITE;
                READ:    cmd_s = CMD_READ;
                CLEAR:   cmd_s = CMD_RESET;
                default: cmd_s = CMD_NONE;
            endcase
        end
    end

    // Occupancy, wait timer and data registers.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            count_r     <= {CNT_W{1'b0}};
            wait_r      <= {WAIT_W{1'b0}};
            node_data_r <= {DATA_W{1'b0}};
            deq_data_r  <= {DATA_W{1'b0}};
            deq_valid_r <= 1'b0;
        end else begin
            deq_valid_r <= deq_done_s;
            if (clr_fire_s) begin
                count_r <= {CNT_W{1'b0}};
            end else if (enq_fire_s) begin
                count_r <= count_r + CNT_W'(1'b1);
            end else if (deq_done_s && !empty_s) begin
                count_r <= count_r - CNT_W'(1'b1);
            end else begin
                count_r <= count_r;
            end
            if (enq_fire_s) begin
                node_data_r <= enq_data_i;
            end else begin
                node_data_r <= node_data_r;
            end
            if (state_r == READ) begin
                wait_r <= WAIT_LOAD;
            end else if ((state_r == WAIT) && (wait_r != {WAIT_W{1'b0}})) begin
                wait_r <= wait_r - WAIT_W'(1'b1);
            end else begin
                wait_r <= wait_r;
            end
            if (deq_done_s) begin
                deq_data_r <= node_data_i;
            end else begin
                deq_data_r <= deq_data_r;
            end
        end
    end

    assign pulses_s                                  = cmd_to_pulses(cmd_s);
    assign {node_write_o, node_read_o, node_reset_o} = pulses_s;
    assign node_data_o = node_write_o ? node_data_r : {DATA_W{1'b0}};
    assign enq_ready_o = enq_ready_s;
    assign deq_ready_o = deq_ready_s;
    assign deq_valid_o = deq_valid_r;
    assign deq_data_o  = deq_data_r;
    assign count_o     = count_r;
    assign full_o      = full_s;
    assign empty_o     = empty_s;

`ifdef QUICKQ_HEAD_STATS_EN
    quickq_sat_ctr #(.W(32)) u_enq_ctr (
        .clk     (clk),
        .reset_i (reset_i),
        .inc_i   (enq_fire_s),
        .count_o (enq_cnt_o)
    );

    quickq_sat_ctr #(.W(32)) u_deq_ctr (
        .clk     (clk),
        .reset_i (reset_i),
        .inc_i   (deq_done_s),
        .count_o (deq_cnt_o)
    );
`endif

endmodule

// File: tb/tb_quickq_head.sv
// Bench for quickq_head: node-chain model plus a scoreboard of expected dequeue values.
module tb_quickq_head;

    localparam int DW = 16;
    localparam int DP = 4;
    localparam int RL = 2;
    localparam int CW = $clog2(DP + 1);

    logic          clk = 1'b0;
    logic          reset_i, enq_valid_i, deq_req_i, clr_i;
    logic [DW-1:0] enq_data_i, node_data_i;
    logic          enq_ready_o, deq_ready_o, deq_valid_o;
    logic [DW-1:0] deq_data_o, node_data_o;
    logic          node_write_o, node_read_o, node_reset_o;
    logic [CW-1:0] count_o;
    logic          full_o, empty_o;
`ifdef QUICKQ_HEAD_STATS_EN
    logic [31:0]   enq_cnt_o, deq_cnt_o;
    int            n_enq_acc = 0;
    int            n_deq_done = 0;
`endif

    int            n_checks = 0;
    int            n_fail   = 0;
    int            rd_cd    = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] chain_q[$];

    always #5 clk = ~clk;

    quickq_head #(.DATA_W(DW), .DEPTH(DP), .RD_LAT(RL)) dut (
        .clk          (clk),
        .reset_i      (reset_i),
        .enq_valid_i  (enq_valid_i),
        .enq_data_i   (enq_data_i),
        .enq_ready_o  (enq_ready_o),
        .deq_req_i    (deq_req_i),
        .deq_ready_o  (deq_ready_o),
        .deq_valid_o  (deq_valid_o),
        .deq_data_o   (deq_data_o),
        .clr_i        (clr_i),
        .node_write_o (node_write_o),
        .node_read_o  (node_read_o),
        .node_reset_o (node_reset_o),
        .node_data_o  (node_data_o),
        .node_data_i  (node_data_i),
`ifdef QUICKQ_HEAD_STATS_EN
        .enq_cnt_o    (enq_cnt_o),
        .deq_cnt_o    (deq_cnt_o),
`endif
        .count_o      (count_o),
        .full_o       (full_o),
        .empty_o      (empty_o)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard and node-chain bookkeeping for the current cycle, then advance one clock.
    task automatic step();
        #1;
        if (enq_valid_i && enq_ready_o) exp_q.push_back(enq_data_i);
        if (node_write_o) chain_q.push_back(node_data_o);
        if (node_read_o) rd_cd = RL;
        if (deq_valid_o) begin
            if (exp_q.size() == 0) check_val("deq_unexpected", 32'(deq_valid_o), 32'd0);
            else check_val("deq_data", 32'(deq_data_o), 32'(exp_q.pop_front()));
        end
`ifdef QUICKQ_HEAD_STATS_EN
        if (enq_valid_i && enq_ready_o) n_enq_acc++;
        if (deq_valid_o) n_deq_done++;
        if (reset_i) begin
            n_enq_acc  = 0;
            n_deq_done = 0;
        end
`endif
        if (node_reset_o) begin
            chain_q.delete();
            exp_q.delete();
            rd_cd = 0;
        end
        check_val("cmd_exclusive",
                  32'({node_write_o, node_read_o, node_reset_o} inside {3'b000, 3'b001, 3'b010, 3'b100}),
                  32'd1);
        check_val("count_bound", 32'(count_o <= CW'(DP)), 32'd1);
        @(posedge clk);
        #1;
        // The chain presents the head value for exactly one cycle, RL cycles after the read pulse.
        if (rd_cd == 1) begin
            rd_cd = 0;
            node_data_i = (chain_q.size() > 0) ? chain_q.pop_front() : 16'hBEEF;
        end else begin
            if (rd_cd > 1) rd_cd--;
            node_data_i = 16'hDEAD;
        end
    endtask

    task automatic wait_deq();
        int n = 0;
        #1;
        while (!deq_valid_o && n < 10) begin
            step();
            #1;
            n++;
        end
        check_val("deq_timeout", 32'(deq_valid_o), 32'd1);
        step();
    endtask

    task automatic do_enq(input logic [DW-1:0] v);
        int n = 0;
        enq_valid_i = 1'b1;
        enq_data_i  = v;
        #1;
        while (!enq_ready_o && n < 20) begin
            step();
            #1;
            n++;
        end
        check_val("enq_timeout", 32'(enq_ready_o), 32'd1);
        step();
        enq_valid_i = 1'b0;
        repeat (2) step();
    endtask

    task automatic do_deq();
        deq_req_i = 1'b1;
        #1;
        check_val("deq_accept", 32'(deq_ready_o), 32'd1);
        step();
        deq_req_i = 1'b0;
        wait_deq();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b1; enq_valid_i = 1'b0; enq_data_i = 16'h0000;
        deq_req_i = 1'b0; clr_i = 1'b0; node_data_i = 16'hDEAD;
        @(posedge clk);
        #2;
        check_val("rst_node_reset", 32'(node_reset_o), 32'd1);
        check_val("rst_enq_ready", 32'(enq_ready_o), 32'd0);
        step(); step();
        reset_i = 1'b0;
        #1;
        check_val("rst_count", 32'(count_o), 32'd0);
        check_val("rst_empty", 32'(empty_o), 32'd1);
        check_val("rst_full", 32'(full_o), 32'd0);
        check_val("rst_deq_valid", 32'(deq_valid_o), 32'd0);
        check_val("rst_deq_data", 32'(deq_data_o), 32'd0);
        check_val("rst_pulses", 32'({node_write_o, node_read_o, node_reset_o}), 32'd0);
        check_val("rst_enq_ready_idle", 32'(enq_ready_o), 32'd1);
        check_val("rst_deq_ready_idle", 32'(deq_ready_o), 32'd0);

        // Single enqueue: write pulse one cycle after acceptance, ready again three cycles later.
        enq_valid_i = 1'b1; enq_data_i = 16'h0005;
        #1;
        check_val("e1_ready", 32'(enq_ready_o), 32'd1);
        step();
        enq_valid_i = 1'b0;
        #1;
        check_val("e1_write", 32'(node_write_o), 32'd1);
        check_val("e1_data", 32'(node_data_o), 32'h0005);
        check_val("e1_count", 32'(count_o), 32'd1);
        check_val("e1_busy", 32'(enq_ready_o), 32'd0);
        step();
        #1;
        check_val("e1_gap_write", 32'(node_write_o), 32'd0);
        check_val("e1_gap_ready", 32'(enq_ready_o), 32'd0);
        step();
        #1;
        check_val("e1_ready_again", 32'(enq_ready_o), 32'd1);
        repeat (3) step();

        // Single dequeue with RL=2: read at N+1, result at N+4.
        deq_req_i = 1'b1;
        #1;
        check_val("d1_ready", 32'(deq_ready_o), 32'd1);
        step();
        deq_req_i = 1'b0;
        #1;
        check_val("d1_read", 32'(node_read_o), 32'd1);
        step();
        #1;
        check_val("d1_wait1_read", 32'(node_read_o), 32'd0);
        check_val("d1_wait1_valid", 32'(deq_valid_o), 32'd0);
        step();
        #1;
        check_val("d1_wait2_valid", 32'(deq_valid_o), 32'd0);
        step();
        #1;
        check_val("d1_valid", 32'(deq_valid_o), 32'd1);
        check_val("d1_data", 32'(deq_data_o), 32'h0005);
        check_val("d1_empty", 32'(empty_o), 32'd1);
        check_val("d1_count", 32'(count_o), 32'd0);
        step();
        #1;
        check_val("d1_pulse_end", 32'(deq_valid_o), 32'd0);
        check_val("d1_hold", 32'(deq_data_o), 32'h0005);

        // Fill to DEPTH, then hold an enqueue against a full queue.
        do_enq(16'h1111); do_enq(16'h2222); do_enq(16'h3333); do_enq(16'h4444);
        #1;
        check_val("full_flag", 32'(full_o), 32'd1);
        check_val("full_count", 32'(count_o), 32'd4);
        enq_valid_i = 1'b1; enq_data_i = 16'h9999;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_val("full_enq_ready", 32'(enq_ready_o), 32'd0);
            check_val("full_no_write", 32'(node_write_o), 32'd0);
            check_val("full_count_hold", 32'(count_o), 32'd4);
            step();
        end
        enq_valid_i = 1'b0;

        do_deq(); do_deq();
        do_enq(16'h5555);
        #1;
        check_val("pre_clr_count", 32'(count_o), 32'd3);

        // Clear beats dequeue and enqueue.
        clr_i = 1'b1; deq_req_i = 1'b1; enq_valid_i = 1'b1; enq_data_i = 16'h7777;
        #1;
        check_val("clr_enq_ready", 32'(enq_ready_o), 32'd0);
        check_val("clr_deq_ready", 32'(deq_ready_o), 32'd0);
        step();
        clr_i = 1'b0; deq_req_i = 1'b0; enq_valid_i = 1'b0;
        #1;
        check_val("clr_pulse", 32'(node_reset_o), 32'd1);
        check_val("clr_no_rw", 32'({node_write_o, node_read_o}), 32'd0);
        check_val("clr_count", 32'(count_o), 32'd0);
        step();
        #1;
        check_val("clr_single", 32'(node_reset_o), 32'd0);
        check_val("clr_empty", 32'(empty_o), 32'd1);

        // Dequeue beats enqueue.
        do_enq(16'h6666);
        enq_valid_i = 1'b1; enq_data_i = 16'h7777; deq_req_i = 1'b1;
        #1;
        check_val("prio_enq_ready", 32'(enq_ready_o), 32'd0);
        check_val("prio_deq_ready", 32'(deq_ready_o), 32'd1);
        step();
        enq_valid_i = 1'b0; deq_req_i = 1'b0;
        wait_deq();

        // Dequeue on an empty queue is refused.
        deq_req_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("empty_deq_ready", 32'(deq_ready_o), 32'd0);
            check_val("empty_no_read", 32'(node_read_o), 32'd0);
            step();
        end
        deq_req_i = 1'b0;

        // Clear outside IDLE is ignored.
        enq_valid_i = 1'b1; enq_data_i = 16'h8888;
        step();
        enq_valid_i = 1'b0; clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        #1;
        check_val("clr_ignored", 32'(node_reset_o), 32'd0);
        check_val("clr_ignored_count", 32'(count_o), 32'd1);
        repeat (2) step();

        // Reset in WAIT aborts the dequeue.
        deq_req_i = 1'b1;
        step();
        deq_req_i = 1'b0;
        step();
        reset_i = 1'b1;
        #1;
        check_val("rw_node_reset", 32'(node_reset_o), 32'd1);
        check_val("rw_no_read", 32'(node_read_o), 32'd0);
        step();
        reset_i = 1'b0;
        #1;
        check_val("rw_no_valid", 32'(deq_valid_o), 32'd0);
        check_val("rw_count", 32'(count_o), 32'd0);
        check_val("rw_empty", 32'(empty_o), 32'd1);
        check_val("rw_full", 32'(full_o), 32'd0);
        check_val("rw_deq_data", 32'(deq_data_o), 32'd0);
        check_val("rw_pulses", 32'({node_write_o, node_read_o, node_reset_o}), 32'd0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check_val("rw_quiet", 32'(deq_valid_o), 32'd0);
            step();
        end

        // Random traffic against the scoreboard.
        for (int i = 0; i < 300; i++) begin
            enq_valid_i = 1'($urandom_range(0, 1));
            enq_data_i  = 16'($urandom);
            deq_req_i   = ($urandom_range(0, 2) == 0);
            clr_i       = ($urandom_range(0, 63) == 0);
            step();
        end
        enq_valid_i = 1'b0; deq_req_i = 1'b0; clr_i = 1'b0;
        repeat (8) step();
        #1;
        check_val("drain_count", 32'(count_o), 32'(exp_q.size()));
        for (int i = 0; i < DP && count_o != '0; i++) do_deq();
        #1;
        check_val("drain_empty", 32'(empty_o), 32'd1);
        check_val("sb_empty", 32'(exp_q.size()), 32'd0);

`ifdef QUICKQ_HEAD_STATS_EN
        check_val("stat_enq", enq_cnt_o, 32'(n_enq_acc));
        check_val("stat_deq", deq_cnt_o, 32'(n_deq_done));
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        step();
        #1;
        check_val("stat_enq_clr", enq_cnt_o, 32'(n_enq_acc));
        check_val("stat_deq_clr", deq_cnt_o, 32'(n_deq_done));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
